// File: rtl/uart_tx_if.sv
// Byte handshake between the UART command interface (master) and the serial transmitter (slave).
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_en;
  logic                  tx_done;
  logic                  tx_busy;

  modport master (output tx_data, output tx_en, input tx_done, input tx_busy);
  modport slave  (input tx_data, input tx_en, output tx_done, output tx_busy);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: one byte per tx_en accept, one-cycle tx_done per completed frame.
// Define UART_TX_PARITY_EN to insert a parity bit before the stop bit (PARITY_ODD selects odd).
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BPS          = 115200,
  parameter int unsigned SYS_CLK_FREQ = 50000000
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     uart_txd
);

  localparam int unsigned CYCLES_PER_BIT = SYS_CLK_FREQ / BPS;
  localparam int unsigned CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CYCLES_PER_BIT - 1);
  // IDLE is entered one cycle early: the tx_done cycle is the last stop-bit cycle.
  localparam logic [CNT_W-1:0] CNT_STOP_LAST = CNT_W'(CYCLES_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StParity = 3'd4
  } state_e;
  logic parity_q;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3
  } state_e;
`endif

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  done_q;
  logic                  busy_q;

  assign bus.tx_done = done_q;
  assign bus.tx_busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      uart_txd <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          uart_txd <= 1'b1;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
          idx_q    <= '0;
          if (bus.tx_en) begin
            shift_q  <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q <= (^bus.tx_data) ^ PARITY_ODD;
`endif
            state_q  <= StStart;
            uart_txd <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            state_q  <= StData;
            uart_txd <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StData: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= StParity;
              uart_txd <= parity_q;
`else
              state_q  <= StStop;
              uart_txd <= 1'b1;
`endif
            end else begin
              idx_q    <= idx_q + IDX_W'(1);
              uart_txd <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            state_q  <= StStop;
            uart_txd <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        StStop: begin
          if (cnt_q == CNT_STOP_LAST) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          uart_txd <= 1'b1;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
          idx_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed scenarios plus random bytes, checked against an arithmetic frame model.
module tb_uart_tx;
  localparam int DW   = 8;
  localparam int FREQ = 1000;
  localparam int RATE = 100;
  localparam int CPB  = FREQ / RATE;
`ifdef UART_TX_PARITY_EN
  localparam bit ODD   = 1'b0;
  localparam int FRAME = (DW + 3) * CPB;
`else
  localparam int FRAME = (DW + 2) * CPB;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_txd;
  int   total = 0;
  int   bad = 0;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(
    .DATA_WIDTH  (DW),
    .BPS         (RATE),
    .SYS_CLK_FREQ(FREQ)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD  (ODD)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected line level k cycles after the accept edge (k = 1..FRAME).
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int idx;
    idx = (k - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == DW + 1) return (^b) ^ ODD;
`endif
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tx_en = 1'b0;
      @(negedge clk);
      chk("idle_txd", uart_txd, 1);
      chk("idle_busy", bus.tx_busy, 0);
      chk("idle_done", bus.tx_done, 0);
    end
  endtask

  // Requests byte b and checks every cycle of its frame. hold keeps tx_en high throughout,
  // inj_k pulses tx_en with inj_b mid-frame, rst_k asserts reset at that cycle and stops.
  task automatic frame(input logic [7:0] b, input bit hold, input int inj_k,
                       input logic [7:0] inj_b, input int rst_k);
    bus.tx_data = b;
    bus.tx_en   = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_done", bus.tx_done, 0);
        return;
      end
      chk($sformatf("line b=%0h k=%0d", b, k), uart_txd, exp_line(b, k));
      chk($sformatf("busy b=%0h k=%0d", b, k), bus.tx_busy, (k < FRAME) ? 1 : 0);
      chk($sformatf("done b=%0h k=%0d", b, k), bus.tx_done, (k == FRAME) ? 1 : 0);
      bus.tx_en   = hold || (k == inj_k);
      bus.tx_data = (k == inj_k) ? inj_b : 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] rb;
    bus.tx_en   = 1'b0;
    bus.tx_data = '0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_txd", uart_txd, 1);
    chk("reset_busy", bus.tx_busy, 0);
    chk("reset_done", bus.tx_done, 0);
    rst_n = 1'b1;
    idle(3);

    // Basic frame with a request arriving mid-frame that must be dropped.
    frame(8'hA5, 1'b0, 35, 8'hFF, 0);
    idle(FRAME + 5);

    // tx_en held high: frames chain with no gap beyond the stop bit.
    frame(8'h00, 1'b1, 0, 8'h00, 0);
    frame(8'hFF, 1'b1, 0, 8'h00, 0);
    frame(8'h5A, 1'b0, 0, 8'h00, 0);
    idle(5);

    // Reset mid-frame, then a clean frame after release.
    frame(8'h00, 1'b0, 0, 8'h00, 47);
    idle(3);
    rst_n = 1'b1;
    idle(20);
    frame(8'h3C, 1'b0, 0, 8'h00, 0);
    idle(3);

    // Command 16'h8155 split into two bytes, second requested in the tx_done cycle.
    frame(8'h81, 1'b0, 0, 8'h00, 0);
    frame(8'h55, 1'b0, 0, 8'h00, 0);
    idle(3);

    // Random bytes, random ignored requests, random gaps (zero gap chains directly).
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom);
      frame(rb, 1'b0, int'($urandom_range(2, FRAME - 1)), 8'($urandom), 0);
      idle(int'($urandom_range(0, 4)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter for the UART path. It sits directly downstream of the UART command interface, which splits 16-bit command packets into bytes and presents them on tx_data/tx_en. This block accepts one byte per tx_en strobe and serialises it onto uart_txd as an 8N1 frame (start, data LSB-first, stop). It returns a one-cycle tx_done pulse when the stop bit completes, which the interface uses to send the next byte or return to idle.

Parameters:
DATA_WIDTH, 8, data bits per frame
BPS, 115200, line rate in bits/s
SYS_CLK_FREQ, 50000000, clk frequency in Hz
CYCLES_PER_BIT (localparam), SYS_CLK_FREQ/BPS with integer truncation (434 at defaults), clk cycles per bit; must be >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
tx_data  input  DATA_WIDTH  byte to send; sampled only on the accept edge
tx_en  input  1  send request; level-sampled in IDLE
tx_done  output  1  one-cycle pulse, frame complete
tx_busy  output  1  high while a frame is in progress
uart_txd  output  1  serial line, idle high

Behaviour:
- Reset (async): state IDLE, uart_txd=1, tx_done=0, tx_busy=0, bit counter=0, cycle counter=0, shift register=0. All outputs are registered.
- States: IDLE, START, DATA, STOP (PARITY when the optional feature is enabled).
- IDLE: uart_txd=1. On a clk edge with tx_en=1 (the accept edge E0), latch tx_data into the shift register and go to START. From the cycle after E0: uart_txd=0 and tx_busy=1.
- START: hold 0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: uart_txd = shift[0] for CYCLES_PER_BIT cycles, then shift right and increment the index. After bit DATA_WIDTH-1 completes, go to STOP.
- STOP: uart_txd=1 for CYCLES_PER_BIT cycles, then go to IDLE.
- On the IDLE-entry edge: tx_done=1 for exactly one cycle and tx_busy=0 in that same cycle.
- Timing: the frame occupies (DATA_WIDTH+2)*CYCLES_PER_BIT cycles starting the cycle after E0. tx_done is high in cycle E0+(DATA_WIDTH+2)*CYCLES_PER_BIT.
- Cycle counter: runs 0..CYCLES_PER_BIT-1 and wraps to 0 at each bit boundary. It is held at 0 in IDLE.
- tx_en while tx_busy=1 is ignored: no queuing, and the in-flight data is unaffected. tx_data changes after E0 have no effect.
- Back-to-back: tx_en=1 in the tx_done cycle is accepted (the state is IDLE). The next start bit begins the following cycle, so there is no idle gap beyond one stop bit.
- tx_en held high continuously: frames are sent back-to-back, one accept per tx_done.
- Reset asserted mid-frame: uart_txd returns to 1 immediately and tx_done is not pulsed. After release, the block waits in IDLE.
- Unreachable state encodings: recover to IDLE with uart_txd=1.

Optional Feature:
UART_TX_PARITY_EN
- Defined: adds parameter PARITY_ODD (default 0) and a PARITY state between DATA and STOP, lasting CYCLES_PER_BIT cycles.
  - Parity bit = XOR of the latched data (even), or its inverse when PARITY_ODD=1.
  - Frame length becomes (DATA_WIDTH+3)*CYCLES_PER_BIT, and tx_done shifts accordingly.
- Undefined: no PARITY state and no parity logic; 8N1 framing exactly as above.

Test Plan:
- SYS_CLK_FREQ=1000, BPS=100 (CPB=10). Reset, then tx_data=8'hA5 with tx_en for one cycle → uart_txd is 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles. tx_done pulses once at cycle E0+100, and tx_busy is high for cycles E0+1..E0+99.
- Mid-frame, tx_en=1 with tx_data=8'hFF at E0+35 → frame is still 8'hA5 and no extra frame follows.
- tx_en held high, tx_data=8'h00 then 8'hFF applied in the tx_done cycle → second start bit at E0+101, and the line shows no high gap beyond the 10-cycle stop bit.
- rst_n pulsed low at E0+47 → uart_txd=1 asynchronously, tx_busy=0, no tx_done. A later 8'h3C sends a clean frame.
- Paired with the command interface sending cmd=16'h8155 → two frames, 8'h81 then 8'h55, with two tx_done pulses.
- With UART_TX_PARITY_EN, PARITY_ODD=0, data 8'h07 → parity bit 1 during cycles E0+91..E0+100, tx_done at E0+110. With PARITY_ODD=1 → parity bit 0.
